// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } rx_state_t;

   localparam int MIN_DATA_BITS = 5;

   typedef struct packed {
      logic brk;
      logic frame_err;
      logic parity_err;
   } rx_status_t;

   // Out-of-range widths saturate to the nearest supported value.
   function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input int max_bits);
      if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
      if (req > 4'(max_bits))      return 4'(max_bits);
      return req;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO for received frames; the head is held in a
// register so it is reset to zero and keeps its last value when empty.
module uart_rx_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   output logic                   drop,
   input  logic                   pop,
   output logic                   valid,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [AW:0]      count_nxt;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign full    = (count == (AW+1)'(DEPTH));
   assign valid   = (count != '0);
   assign do_pop  = valid && pop;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign rd_nxt  = rd_ptr + AW'(do_pop);

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)      count_nxt = count + 1'b1;
      else if (!do_push && do_pop) count_nxt = count - 1'b1;
   end

   // NOTE: storage has no reset; only the pointers, count and head register
   // need a known value, and leaving the array unreset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_nxt;
         count  <= count_nxt;
         // The word being written bypasses the array when it becomes the head.
         if (count_nxt != '0)
            head <= (do_push && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: input synchroniser, mid-bit sampling FSM with
// parity/framing/break detection, and a valid/ready output FIFO.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 8,
   parameter int OVERSAMPLE    = 16,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          baud_tick,
   input  logic                          rx,
   input  logic [3:0]                    cfg_data_bits,
   input  logic                          cfg_parity_en,
   input  logic                          cfg_parity_odd,
   input  logic                          cfg_stop2,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [MAX_DATA_BITS-1:0]      m_data,
   output logic                          m_parity_err,
   output logic                          m_frame_err,
   output logic                          m_break,
   output logic                          overrun,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int EW = $bits(rx_status_t) + MAX_DATA_BITS;

   rx_state_t state, state_nxt;

   logic                     rx_meta, rx_s;
   logic [TW-1:0]            tick_cnt;
   logic [3:0]               bit_cnt;
   logic [3:0]               bits_q;
   logic                     par_en_q, par_odd_q, stop2_q;
   logic [MAX_DATA_BITS-1:0] shreg;
   logic                     par_acc, perr_q, ferr_q;
   logic                     brk_cand, brk_q;
   logic                     stop_cnt;

   logic tick_clr, tick_inc;
   logic start_ok, data_smp, par_smp, stop_smp, push;
   logic half_pt, bit_pt, last_data, last_stop;
   logic brk_now, ferr_now;
   logic fifo_drop;

   rx_status_t       status, head_status;
   logic [EW-1:0]    push_data, head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign half_pt   = (tick_cnt == TW'(OVERSAMPLE/2 - 1));
   assign bit_pt    = (tick_cnt == TW'(OVERSAMPLE - 1));
   assign last_data = (bit_cnt == bits_q - 4'd1);
   assign last_stop = !stop2_q || stop_cnt;
   // Break is decided on the first stop bit and carried to a second one.
   assign brk_now   = stop_cnt ? brk_q : (brk_cand && !rx_s);
   assign ferr_now  = ferr_q || !rx_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      tick_clr  = 1'b0;
      tick_inc  = 1'b0;
      start_ok  = 1'b0;
      data_smp  = 1'b0;
      par_smp   = 1'b0;
      stop_smp  = 1'b0;
      push      = 1'b0;
      if (baud_tick) begin
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nxt = START;
                  tick_clr  = 1'b1;
               end
            end
            START: begin
               if (half_pt) begin
                  tick_clr = 1'b1;
                  if (rx_s) begin
                     state_nxt = IDLE;
                  end else begin
                     start_ok  = 1'b1;
                     state_nxt = DATA;
                  end
               end else begin
                  tick_inc = 1'b1;
               end
            end
            DATA: begin
               if (bit_pt) begin
                  tick_clr = 1'b1;
                  data_smp = 1'b1;
                  if (last_data) state_nxt = par_en_q ? PARITY : STOP;
               end else begin
                  tick_inc = 1'b1;
               end
            end
            PARITY: begin
               if (bit_pt) begin
                  tick_clr  = 1'b1;
                  par_smp   = 1'b1;
                  state_nxt = STOP;
               end else begin
                  tick_inc = 1'b1;
               end
            end
            STOP: begin
               if (bit_pt) begin
                  tick_clr = 1'b1;
                  stop_smp = 1'b1;
                  // Pushing at mid-bit leaves half a bit to catch a back-to-back start.
                  if (last_stop) begin
                     push      = 1'b1;
                     state_nxt = brk_now ? BRK_WAIT : IDLE;
                  end
               end else begin
                  tick_inc = 1'b1;
               end
            end
            BRK_WAIT: begin
               if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         bits_q    <= 4'(MIN_DATA_BITS);
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         stop2_q   <= 1'b0;
         shreg     <= '0;
         par_acc   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         brk_cand  <= 1'b0;
         brk_q     <= 1'b0;
         stop_cnt  <= 1'b0;
      end else begin
         if (tick_clr)      tick_cnt <= '0;
         else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;

         if (start_ok) begin
            bits_q    <= clamp_data_bits(cfg_data_bits, MAX_DATA_BITS);
            par_en_q  <= cfg_parity_en;
            par_odd_q <= cfg_parity_odd;
            stop2_q   <= cfg_stop2;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_acc   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_cand  <= 1'b1;
            brk_q     <= 1'b0;
            stop_cnt  <= 1'b0;
         end

         // Bits land at their final position, so the word is right-aligned.
         if (data_smp) begin
            shreg   <= shreg | (MAX_DATA_BITS'(rx_s) << bit_cnt);
            bit_cnt <= bit_cnt + 4'd1;
            par_acc <= par_acc ^ rx_s;
            if (rx_s) brk_cand <= 1'b0;
         end

         if (par_smp) begin
            perr_q <= par_acc ^ rx_s ^ par_odd_q;
            if (rx_s) brk_cand <= 1'b0;
         end

         if (stop_smp) begin
            stop_cnt <= 1'b1;
            ferr_q   <= ferr_now;
            if (!stop_cnt) brk_q <= brk_now;
         end
      end
   end

   always_comb begin
      status.brk        = brk_now;
      status.frame_err  = ferr_now;
      status.parity_err = perr_q;
   end

   assign push_data = {status, shreg};

   uart_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .drop      (fifo_drop),
      .pop       (m_ready),
      .valid     (m_valid),
      .head      (head),
      .count     (fifo_count)
   );

   assign {head_status, m_data} = head;
   assign m_break      = head_status.brk;
   assign m_frame_err  = head_status.frame_err;
   assign m_parity_err = head_status.parity_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overrun <= 1'b0;
      else        overrun <= fifo_drop;
   end

   assign busy = (state != IDLE);

endmodule
